// File: rtl/dm_bus_arbiter.sv
// dm_bus_arbiter: shares the data-memory port between the CPU (m0) and an aux master (m1); ARB_ROUND_ROBIN_EN selects round-robin.
// Grant and forwarding are combinational, read data returns 1 cycle later; no request buffering, masters hold req until gnt.
module dm_bus_arbiter #(
   parameter int AW         = 32,
   parameter int DW         = 32,
   parameter int STARVE_MAX = 4
) (
   input  logic          clk,
   input  logic          reset,
   input  logic          m0_req,
   input  logic          m0_lock,
   input  logic [AW-1:0] m0_addr,
   input  logic [DW-1:0] m0_wdata,
   input  logic [3:0]    m0_byteen,
   output logic          m0_gnt,
   output logic          m0_rvalid,
   output logic [DW-1:0] m0_rdata,
   input  logic          m1_req,
   input  logic [AW-1:0] m1_addr,
   input  logic [DW-1:0] m1_wdata,
   input  logic [3:0]    m1_byteen,
   output logic          m1_gnt,
   output logic          m1_rvalid,
   output logic [DW-1:0] m1_rdata,
   output logic [AW-1:0] mem_addr,
   output logic [DW-1:0] mem_wdata,
   output logic [3:0]    mem_byteen,
   output logic          mem_re,
   input  logic [DW-1:0] mem_rdata
);

   logic lock_owner;
   logic rd_m0;
   logic rd_m1;
   logic g0;
   logic g1;

`ifdef ARB_ROUND_ROBIN_EN
   // last_gnt=1 means m1 was granted most recently, so m0 wins the next conflict
   logic last_gnt;

   always_comb begin
      g0 = 1'b0;
      g1 = 1'b0;
      if (reset) begin
         if (lock_owner && m0_req) begin
            g0 = 1'b1;
         end else if (m0_req && m1_req) begin
            g0 = last_gnt;
            g1 = ~last_gnt;
         end else begin
            g0 = m0_req;
            g1 = m1_req;
         end
      end
   end

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         last_gnt <= 1'b1;
      end else if (g0) begin
         last_gnt <= 1'b0;
      end else if (g1) begin
         last_gnt <= 1'b1;
      end
   end
`else
   logic [3:0] starve_cnt;
   logic       starved;

   assign starved = (starve_cnt == 4'(STARVE_MAX));

   always_comb begin
      g0 = 1'b0;
      g1 = 1'b0;
      if (reset) begin
         if (lock_owner && m0_req) begin
            g0 = 1'b1;
         end else if (starved && m1_req) begin
            g1 = 1'b1;
         end else if (m0_req) begin
            g0 = 1'b1;
         end else begin
            g1 = m1_req;
         end
      end
   end

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         starve_cnt <= 4'd0;
      end else if (m1_req && !g1) begin
         if (!starved) starve_cnt <= starve_cnt + 4'd1;
      end else begin
         starve_cnt <= 4'd0;
      end
   end
`endif

   // Lock and read-return tracking
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         lock_owner <= 1'b0;
         rd_m0      <= 1'b0;
         rd_m1      <= 1'b0;
      end else begin
         if (!m0_lock || !m0_req) begin
            lock_owner <= 1'b0;
         end else if (g0) begin
            lock_owner <= 1'b1;
         end
         rd_m0 <= g0 & (m0_byteen == 4'd0);
         rd_m1 <= g1 & (m1_byteen == 4'd0);
      end
   end

   assign m0_gnt = g0;
   assign m1_gnt = g1;

   // AND-OR muxing keeps a non-granted master's inputs off the memory bus
   assign mem_addr   = ({AW{g0}} & m0_addr)   | ({AW{g1}} & m1_addr);
   assign mem_wdata  = ({DW{g0}} & m0_wdata)  | ({DW{g1}} & m1_wdata);
   assign mem_byteen = ({4{g0}}  & m0_byteen) | ({4{g1}}  & m1_byteen);
   assign mem_re     = (g0 & (m0_byteen == 4'd0)) | (g1 & (m1_byteen == 4'd0));

   assign m0_rvalid = rd_m0;
   assign m1_rvalid = rd_m1;
   assign m0_rdata  = {DW{rd_m0}} & mem_rdata;
   assign m1_rdata  = {DW{rd_m1}} & mem_rdata;

endmodule

// File: tb/tb_dm_bus_arbiter.sv
// Bench for dm_bus_arbiter: vector table, directed corner cases and random traffic against a reference model.
module tb_dm_bus_arbiter;
   localparam int AW     = 32;
   localparam int DW     = 32;
   localparam int STARVE = 4;

   logic          clk;
   logic          reset;
   logic          m0_req, m0_lock, m1_req;
   logic [AW-1:0] m0_addr, m1_addr;
   logic [DW-1:0] m0_wdata, m1_wdata;
   logic [3:0]    m0_byteen, m1_byteen;
   logic          m0_gnt, m1_gnt, m0_rvalid, m1_rvalid;
   logic [DW-1:0] m0_rdata, m1_rdata;
   logic [AW-1:0] mem_addr;
   logic [DW-1:0] mem_wdata;
   logic [3:0]    mem_byteen;
   logic          mem_re;
   logic [DW-1:0] mem_rdata;

   dm_bus_arbiter #(.AW(AW), .DW(DW), .STARVE_MAX(STARVE)) dut (
      .clk(clk), .reset(reset),
      .m0_req(m0_req), .m0_lock(m0_lock), .m0_addr(m0_addr), .m0_wdata(m0_wdata),
      .m0_byteen(m0_byteen), .m0_gnt(m0_gnt), .m0_rvalid(m0_rvalid), .m0_rdata(m0_rdata),
      .m1_req(m1_req), .m1_addr(m1_addr), .m1_wdata(m1_wdata), .m1_byteen(m1_byteen),
      .m1_gnt(m1_gnt), .m1_rvalid(m1_rvalid), .m1_rdata(m1_rdata),
      .mem_addr(mem_addr), .mem_wdata(mem_wdata), .mem_byteen(mem_byteen),
      .mem_re(mem_re), .mem_rdata(mem_rdata)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   int nvec = 0;
   int nerr = 0;

   // Reference model state: pending read owner (-1 none), lock, denial count, last winner
   int model_rd;
   bit model_lock;
   int model_starve;
   int model_last;

   // Outputs captured at the most recent check point
   logic          s_g0, s_g1, s_rv0, s_rv1, s_re;
   logic [DW-1:0] s_rd0, s_rd1, s_wdata;
   logic [AW-1:0] s_addr;
   logic [3:0]    s_be;

   task automatic chk(input string name, input logic [159:0] act, input logic [159:0] exp);
      nvec++;
      if (act !== exp) begin
         nerr++;
         $display("FAIL %s: got %0h, expected %0h", name, act, exp);
      end
   endtask

   function automatic void model_clear();
      model_rd     = -1;
      model_lock   = 1'b0;
      model_starve = 0;
      model_last   = 1;
   endfunction

   function automatic int model_winner();
      if (!reset) return -1;
      if (model_lock && m0_req) return 0;
`ifdef ARB_ROUND_ROBIN_EN
      if (m0_req && m1_req) return (model_last == 1) ? 0 : 1;
`else
      if (m1_req && model_starve == STARVE) return 1;
`endif
      if (m0_req) return 0;
      if (m1_req) return 1;
      return -1;
   endfunction

   function automatic void model_update(input int w);
      logic [3:0] be;
      be = (w == 0) ? m0_byteen : m1_byteen;
      model_rd   = (w >= 0 && be == 4'd0) ? w : -1;
      model_lock = (m0_lock && m0_req) ? (model_lock || w == 0) : 1'b0;
      if (m1_req && w != 1) model_starve = (model_starve < STARVE) ? model_starve + 1 : STARVE;
      else model_starve = 0;
      if (w >= 0) model_last = w;
   endfunction

   // One clock: check outputs on the falling edge, advance the model on the rising edge
   task automatic cyc(input string name);
      int w;
      logic [3:0]    e_be;
      logic [AW-1:0] e_addr;
      logic [DW-1:0] e_wd;
      logic          e_re;
      if (!reset) model_clear();
      @(negedge clk);
      w      = model_winner();
      e_be   = (w == 0) ? m0_byteen : (w == 1) ? m1_byteen : 4'd0;
      e_addr = (w == 0) ? m0_addr   : (w == 1) ? m1_addr   : '0;
      e_wd   = (w == 0) ? m0_wdata  : (w == 1) ? m1_wdata  : '0;
      e_re   = (w >= 0) && (e_be == 4'd0);
      chk(name,
          {m0_gnt, m1_gnt, m0_rvalid, m1_rvalid, m0_rdata, m1_rdata, mem_addr, mem_wdata, mem_byteen, mem_re},
          {w == 0, w == 1, model_rd == 0, model_rd == 1,
           (model_rd == 0) ? mem_rdata : 32'd0, (model_rd == 1) ? mem_rdata : 32'd0,
           e_addr, e_wd, e_be, e_re});
      s_g0 = m0_gnt;  s_g1 = m1_gnt;  s_rv0 = m0_rvalid; s_rv1 = m1_rvalid;
      s_rd0 = m0_rdata; s_rd1 = m1_rdata; s_addr = mem_addr; s_wdata = mem_wdata;
      s_be = mem_byteen; s_re = mem_re;
      @(posedge clk);
      if (!reset) model_clear();
      else model_update(w);
      #1;
   endtask

   typedef struct {
      logic          m0_req;
      logic          m0_lock;
      logic [3:0]    m0_be;
      logic          m1_req;
      logic [3:0]    m1_be;
      logic          e_g0;
      logic          e_g1;
      logic [3:0]    e_be;
      logic          e_re;
      logic [AW-1:0] e_addr;
   } vec_t;

   vec_t tbl[17];

   initial begin
      model_clear();
      reset = 1'b1;
      {m0_req, m0_lock, m1_req} = '0;
      m0_addr = '0; m1_addr = '0; m0_wdata = '0; m1_wdata = '0;
      m0_byteen = '0; m1_byteen = '0; mem_rdata = '0;

`ifndef ARB_ROUND_ROBIN_EN
      // Starvation: m0 reads 0x100, m1 writes 0x1234 to 0x20
      tbl[0]  = '{1'b1, 1'b0, 4'h0, 1'b1, 4'hF, 1'b1, 1'b0, 4'h0, 1'b1, 32'h100};
      tbl[1]  = '{1'b1, 1'b0, 4'h0, 1'b1, 4'hF, 1'b1, 1'b0, 4'h0, 1'b1, 32'h100};
      tbl[2]  = '{1'b1, 1'b0, 4'h0, 1'b1, 4'hF, 1'b1, 1'b0, 4'h0, 1'b1, 32'h100};
      tbl[3]  = '{1'b1, 1'b0, 4'h0, 1'b1, 4'hF, 1'b1, 1'b0, 4'h0, 1'b1, 32'h100};
      tbl[4]  = '{1'b1, 1'b0, 4'h0, 1'b1, 4'hF, 1'b0, 1'b1, 4'hF, 1'b0, 32'h20};
      tbl[5]  = '{1'b1, 1'b0, 4'h0, 1'b1, 4'hF, 1'b1, 1'b0, 4'h0, 1'b1, 32'h100};
      tbl[6]  = '{1'b0, 1'b0, 4'h0, 1'b0, 4'h0, 1'b0, 1'b0, 4'h0, 1'b0, 32'h0};
      // Lock holds m1 off past the starvation limit; released one cycle after lock drops
      for (int i = 7; i < 14; i++)
         tbl[i] = '{1'b1, 1'b1, 4'h0, 1'b1, 4'h0, 1'b1, 1'b0, 4'h0, 1'b1, 32'h100};
      tbl[14] = '{1'b1, 1'b0, 4'h0, 1'b1, 4'h0, 1'b1, 1'b0, 4'h0, 1'b1, 32'h100};
      tbl[15] = '{1'b1, 1'b0, 4'h0, 1'b1, 4'h0, 1'b0, 1'b1, 4'h0, 1'b1, 32'h20};
      tbl[16] = '{1'b1, 1'b0, 4'h0, 1'b1, 4'h0, 1'b1, 1'b0, 4'h0, 1'b1, 32'h100};
`endif

      #3 reset = 1'b0;
      @(posedge clk); #1;

      // Reset holds every output low even with both masters requesting
      m0_req = 1'b1; m1_req = 1'b1; m1_byteen = 4'hF; m0_addr = 32'h44; m1_addr = 32'h48;
      cyc("reset_hold");
      chk("reset_gnt", {s_g0, s_g1, s_rv0, s_rv1}, 4'b0000);
      chk("reset_mem", {s_addr, s_wdata, s_be, s_re}, '0);
      reset = 1'b1;
      m1_req = 1'b0;
      cyc("reset_release");
      chk("release_m0_gnt", s_g0, 1'b1);

      // Single m0 read returned the next cycle
      m0_req = 1'b1; m0_addr = 32'h10; m0_byteen = 4'h0; m1_req = 1'b0;
      cyc("m0_read");
      chk("m0_read_strobe", {s_re, s_addr}, {1'b1, 32'h10});
      m0_req = 1'b0; mem_rdata = 32'hDEADBEEF;
      cyc("m0_read_ret");
      chk("m0_read_ret", {s_rv0, s_rd0, s_rv1, s_rd1}, {1'b1, 32'hDEADBEEF, 1'b0, 32'h0});

`ifndef ARB_ROUND_ROBIN_EN
      m0_addr = 32'h100; m1_addr = 32'h20; m0_wdata = 32'h0; m1_wdata = 32'h1234;
      for (int i = 0; i < 17; i++) begin
         m0_req = tbl[i].m0_req; m0_lock = tbl[i].m0_lock; m0_byteen = tbl[i].m0_be;
         m1_req = tbl[i].m1_req; m1_byteen = tbl[i].m1_be;
         mem_rdata = $urandom;
         cyc($sformatf("tbl_model_%0d", i));
         chk($sformatf("tbl_%0d", i), {s_g0, s_g1, s_be, s_re, s_addr},
             {tbl[i].e_g0, tbl[i].e_g1, tbl[i].e_be, tbl[i].e_re, tbl[i].e_addr});
      end
`else
      // Round-robin: both requesting straight out of reset alternates starting with m0
      reset = 1'b0; m0_lock = 1'b0;
      cyc("rr_reset");
      reset = 1'b1; m0_req = 1'b1; m1_req = 1'b1; m0_byteen = 4'h0; m1_byteen = 4'h0;
      for (int i = 0; i < 6; i++) begin
         cyc($sformatf("rr_model_%0d", i));
         chk($sformatf("rr_%0d", i), {s_g0, s_g1}, (i % 2 == 0) ? 2'b10 : 2'b01);
      end
`endif

      // Alternating reads: m0 then m1, data A then B, no cross-delivery
      m0_lock = 1'b0; m1_req = 1'b0;
      cyc("idle");
      m0_req = 1'b1; m0_addr = 32'h0; m0_byteen = 4'h0;
      cyc("alt_m0");
      chk("alt_m0_gnt", {s_g0, s_re, s_addr}, {1'b1, 1'b1, 32'h0});
      m0_req = 1'b0; m1_req = 1'b1; m1_addr = 32'h4; m1_byteen = 4'h0; mem_rdata = 32'hAAAA0001;
      cyc("alt_m1");
      chk("alt_ret_a", {s_g1, s_rv0, s_rd0, s_rv1, s_rd1}, {1'b1, 1'b1, 32'hAAAA0001, 1'b0, 32'h0});
      m1_req = 1'b0; mem_rdata = 32'hBBBB0002;
      cyc("alt_ret");
      chk("alt_ret_b", {s_rv0, s_rd0, s_rv1, s_rd1}, {1'b0, 32'h0, 1'b1, 32'hBBBB0002});

      // Reset between a granted read and its return drops the rvalid
      m0_req = 1'b1; m0_byteen = 4'h0;
      cyc("midrd_grant");
      m0_req = 1'b0; reset = 1'b0;
      cyc("midrd_reset");
      chk("midrd_drop", {s_rv0, s_rv1}, 2'b00);
      reset = 1'b1;
      cyc("midrd_after");
      chk("midrd_after", {s_rv0, s_rv1}, 2'b00);

      // Random traffic against the model
      for (int i = 0; i < 400; i++) begin
         reset     = ($urandom_range(0, 63) != 0);
         m0_req    = ($urandom_range(0, 9) < 6);
         m1_req    = ($urandom_range(0, 9) < 6);
         m0_lock   = ($urandom_range(0, 9) < 3);
         m0_byteen = $urandom_range(0, 1) ? 4'h0 : 4'($urandom);
         m1_byteen = $urandom_range(0, 1) ? 4'h0 : 4'($urandom);
         m0_addr   = $urandom; m1_addr  = $urandom;
         m0_wdata  = $urandom; m1_wdata = $urandom;
         mem_rdata = $urandom;
         cyc($sformatf("rand_%0d", i));
      end

      $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
      $finish;
   end
endmodule
